// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift-compare-subtract step per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    // Restored remainder is always < D, so its MSB is zero and is not stored.
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic             bw;
    logic             ge;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    // Borrow-ripple subtract of {0,D} from the (WIDTH+1)-bit shifted remainder.
    always_comb begin
        r_sh = {r_q, q_q[WIDTH-1]};
        diff = '0;
        bw   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff[i] = r_sh[i] ^ d_q[i] ^ bw;
            bw      = (~r_sh[i] & d_q[i]) | (~(r_sh[i] ^ d_q[i]) & bw);
        end
        ge  = r_sh[WIDTH] | ~bw;
        r_d = ge ? diff : r_sh[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            q_q     <= dividend;
                            d_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            state_q <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=4): operands queued at start,
// results checked against integer division when done pulses.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    op_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  dc;

    seq_restoring_divider #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        op_t op;
        op.a = a;
        op.b = b;
        sb.push_back(op);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            op_t op;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                op = sb.pop_front();
                if (op.b == 4'd0) begin
                    check("dbz_flag", dbz, 1);
                    check("dbz_quot", quotient, 15);
                    check("dbz_rem", remainder, op.a);
                end else begin
                    check("quot", quotient, op.a / op.b);
                    check("rem", remainder, op.a % op.b);
                    check("dbz_clear", dbz, 0);
                    check("inv_recon", 32'(quotient) * 32'(op.b) + 32'(remainder), op.a);
                    check("inv_rem_lt", remainder < op.b, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(4'd13, 4'd4);
        for (int i = 0; i < 4; i++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            @(negedge clk);
        end
        check("lat_done", done, 1);
        check("lat_busy", busy, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("hold_quot", quotient, 3);
        check("hold_rem", remainder, 1);

        start_op(4'd15, 4'd1);
        wait_done();
        start_op(4'd3, 4'd7);
        wait_done();
        start_op(4'd15, 4'd15);
        wait_done();
        @(negedge clk);

        start_op(4'd9, 4'd0);
        check("dbz_lat_done", done, 1);
        check("dbz_lat_busy", busy, 0);
        @(negedge clk);
        check("dbz_pulse", done, 0);
        check("dbz_no_busy", busy, 0);

        dc = done_cnt;
        start_op(4'd10, 4'd3);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd8;
        divisor  = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'd15;
        divisor  = 4'd1;
        wait_done();
        start_op(4'd8, 4'd2);
        check("single_done", done_cnt - dc, 1);
        check("b2b_done_drop", done, 0);
        check("b2b_busy", busy, 1);
        wait_done();
        @(negedge clk);

        dc = done_cnt;
        start_op(4'd14, 4'd5);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(4'd14, 4'd5);
        wait_done();
        @(negedge clk);
        check("abort_redo_done", done_cnt - dc, 1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b));
                wait_done();
            end
        end
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
